// File: rtl/hpm_tracer_pkg.sv
// hpm_tracer_pkg: shared types and defaults for the windowed HPM tracer
package hpm_tracer_pkg;
  typedef enum logic {IDLE, MEASURE} state_t;
  localparam int DEF_NUM_CNT = 32;
  localparam int DEF_CNT_W = 64;
  localparam logic [11:0] DEF_TRIG_ADDR = 12'h320;
  localparam logic [31:0] DEF_START_VAL = 32'h0;
  localparam logic [31:0] DEF_STOP_VAL = 32'hFFFF_FFFF;
  localparam int REC_META_W = 40;
  typedef struct packed {
    logic [DEF_NUM_CNT*DEF_CNT_W-1:0] delta;
    logic [31:0] cyc;
    logic [7:0] id;
  } hpm_rec_t;
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return &v ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/hpm_rec_fifo.sv
// hpm_rec_fifo: synchronous record FIFO; a push on full is taken only alongside a pop
module hpm_rec_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_h,
  input  logic             rst_h,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata = empty ? '0 : mem[rp[AW-1:0]];
  // pointer update; extra MSB distinguishes full from empty
  always_ff @(posedge clk_h)
    if (rst_h) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  // storage needs no reset; the head is masked while empty
  always_ff @(posedge clk_h)
    if (do_push) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/hpm_window_tracer.sv
// hpm_window_tracer: CSR-triggered windowed HPM delta tracer with buffered valid/ready output
module hpm_window_tracer
  import hpm_tracer_pkg::*;
#(
  parameter int NUM_CNT = DEF_NUM_CNT,
  parameter int CNT_W = DEF_CNT_W,
  parameter logic [NUM_CNT-1:0] CNT_MASK = '1,
  parameter logic [11:0] TRIG_ADDR = DEF_TRIG_ADDR,
  parameter logic [31:0] START_VAL = DEF_START_VAL,
  parameter logic [31:0] STOP_VAL = DEF_STOP_VAL,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk_h,
  input  logic                     rst_h,
  input  logic                     csr_we_i,
  input  logic [11:0]              csr_addr_i,
  input  logic [31:0]              csr_wdata_i,
  input  logic [NUM_CNT*CNT_W-1:0] hpm_i,
  output logic                     snap_valid_o,
  input  logic                     snap_ready_i,
  output logic [NUM_CNT*CNT_W-1:0] snap_delta_o,
  output logic [31:0]              snap_cyc_o,
  output logic [7:0]               snap_id_o,
  output logic                     busy_o,
  output logic                     ovf_o,
  output logic [7:0]               drop_cnt_o
);
  localparam int DW = NUM_CNT*CNT_W;
  localparam int RW = DW + REC_META_W;
  state_t state_q, state_d;
  logic start_hit, stop_hit, push, pop, full, empty, drop, ovf_q;
  logic [DW-1:0] delta;
  logic [31:0] cyc_q;
  logic [7:0] id_q, drop_q;
  logic [RW-1:0] head;
  assign start_hit = csr_we_i && csr_addr_i == TRIG_ADDR && csr_wdata_i == START_VAL;
  assign stop_hit = csr_we_i && csr_addr_i == TRIG_ADDR && csr_wdata_i == STOP_VAL;
  assign push = stop_hit && state_q == MEASURE;
  assign pop = snap_valid_o && snap_ready_i;
  assign drop = push && full && !pop;
  // state register
  always_ff @(posedge clk_h)
    state_q <= rst_h ? IDLE : state_d;
  // start (or restart) opens a window, stop closes it; stop in IDLE is a no-op
  always_comb begin
    state_d = state_q;
    state_d = start_hit ? MEASURE : stop_hit ? IDLE : state_q;
  end
  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    logic [CNT_W-1:0] base_q;
    // baseline snapshot on every start, including a restart mid-window
    always_ff @(posedge clk_h)
      if (rst_h) base_q <= '0;
      else if (start_hit) base_q <= hpm_i[i*CNT_W +: CNT_W];
    assign delta[i*CNT_W +: CNT_W] = CNT_MASK[i] ? hpm_i[i*CNT_W +: CNT_W] - base_q : '0;
  end
  // window length, sequence id and drop accounting; ids advance on drops too
  always_ff @(posedge clk_h)
    if (rst_h) begin
      cyc_q <= '0;
      id_q <= '0;
      ovf_q <= 1'b0;
      drop_q <= '0;
    end else begin
      if (start_hit) cyc_q <= '0;
      else if (state_q == MEASURE) cyc_q <= sat_inc32(cyc_q);
      if (push) id_q <= id_q + 8'd1;
      if (drop) begin
        ovf_q <= 1'b1;
        drop_q <= &drop_q ? drop_q : drop_q + 8'd1;
      end
    end
  // cyc_q lags the stop cycle by one, so the record carries its increment
  hpm_rec_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(RW)) u_fifo (
    .clk_h (clk_h),
    .rst_h (rst_h),
    .push  (push),
    .pop   (pop),
    .wdata ({delta, sat_inc32(cyc_q), id_q}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );
  assign snap_valid_o = !empty;
  assign {snap_delta_o, snap_cyc_o, snap_id_o} = head;
  assign busy_o = state_q == MEASURE;
  assign ovf_o = ovf_q;
  assign drop_cnt_o = drop_q;
endmodule

// File: tb/tb_hpm_window_tracer.sv
// tb_hpm_window_tracer: randomized scoreboard bench for hpm_window_tracer
module tb_hpm_window_tracer;
  localparam int N = 8;
  localparam int W = 64;
  localparam int D = 4;
  localparam logic [N-1:0] MASK = 8'hDF;
  localparam logic [11:0] TA = 12'h320;
  localparam logic [31:0] SV = 32'h0;
  localparam logic [31:0] PV = 32'hFFFF_FFFF;
  logic clk_h = 0, rst_h = 1, csr_we_i = 0, snap_ready_i = 0;
  logic [11:0] csr_addr_i = '0;
  logic [31:0] csr_wdata_i = '0;
  logic [N*W-1:0] hpm_i = '0;
  logic snap_valid_o, busy_o, ovf_o;
  logic [N*W-1:0] snap_delta_o;
  logic [31:0] snap_cyc_o;
  logic [7:0] snap_id_o, drop_cnt_o;
  hpm_window_tracer #(.NUM_CNT(N), .CNT_W(W), .CNT_MASK(MASK), .FIFO_DEPTH(D)) dut (
    .clk_h(clk_h), .rst_h(rst_h), .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i),
    .csr_wdata_i(csr_wdata_i), .hpm_i(hpm_i), .snap_valid_o(snap_valid_o),
    .snap_ready_i(snap_ready_i), .snap_delta_o(snap_delta_o), .snap_cyc_o(snap_cyc_o),
    .snap_id_o(snap_id_o), .busy_o(busy_o), .ovf_o(ovf_o), .drop_cnt_o(drop_cnt_o)
  );
  always #5 clk_h = ~clk_h;
  typedef struct {
    logic [N*W-1:0] d;
    longint unsigned cyc;
    int id;
  } rec_t;
  rec_t exp_q[$];
  rec_t m;
  int checks = 0, failures = 0;
  logic [W-1:0] hpm[N], base[N];
  bit open, ovf;
  int occ, seq, drops;
  longint unsigned t, t_start;
  task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask
  // consumer side: every accepted record must be the oldest expected one
  always @(negedge clk_h)
    if (!rst_h && snap_valid_o && snap_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_record id=%0d", snap_id_o);
      end else begin
        m = exp_q.pop_front();
        chk("rec_delta", snap_delta_o, m.d);
        chk("rec_cyc", {480'b0, snap_cyc_o}, {448'b0, m.cyc});
        chk("rec_id", {504'b0, snap_id_o}, m.id[7:0]);
      end
    end
  task automatic model_clear();
    exp_q.delete();
    open = 0; ovf = 0; occ = 0; seq = 0; drops = 0;
  endtask
  task automatic reset_dut(input int n);
    rst_h = 1;
    csr_we_i = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk_h); #1;
      chk("rst_valid", snap_valid_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_ovf", ovf_o, 0);
      chk("rst_drop", drop_cnt_o, 0);
      chk("rst_delta", snap_delta_o, 0);
      chk("rst_cyc", snap_cyc_o, 0);
      chk("rst_id", snap_id_o, 0);
    end
    model_clear();
    rst_h = 0;
  endtask
  task automatic step(input bit we, input logic [11:0] a, input logic [31:0] wd);
    bit st, sp;
    rec_t r;
    csr_we_i = we; csr_addr_i = a; csr_wdata_i = wd;
    for (int i = 0; i < N; i++) hpm_i[i*W +: W] = hpm[i];
    st = we && a == TA && wd == SV;
    sp = we && a == TA && wd == PV;
    if (occ > 0 && snap_ready_i) occ--;
    if (st) begin
      open = 1; t_start = t; base = hpm;
    end else if (sp && open) begin
      open = 0;
      for (int i = 0; i < N; i++) r.d[i*W +: W] = MASK[i] ? hpm[i] - base[i] : '0;
      r.cyc = (t - t_start > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : t - t_start;
      r.id = seq % 256;
      seq++;
      if (occ < D) begin
        occ++;
        exp_q.push_back(r);
      end else begin
        drops++;
        ovf = 1;
      end
    end
    t++;
    @(posedge clk_h); #1;
    csr_we_i = 0;
    for (int i = 0; i < N; i++) hpm[i] += W'($urandom_range(0, 3));
    chk("busy", busy_o, open);
    chk("valid", snap_valid_o, occ > 0);
    chk("ovf", ovf_o, ovf);
    chk("drop_cnt", drop_cnt_o, drops > 255 ? 255 : drops);
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, TA, SV);
  endtask
  task automatic window(input int n);
    step(1, TA, SV);
    idle(n);
    step(1, TA, PV);
  endtask
  initial begin
    t = 0;
    for (int i = 0; i < N; i++) hpm[i] = {$urandom, $urandom};
    model_clear();
    reset_dut(3);
    snap_ready_i = 0;
    idle(2);
    hpm[3] = 100;
    step(1, TA, SV);
    idle(14);
    hpm[3] = 160;
    step(1, TA, PV);
    chk("basic_delta3", snap_delta_o[3*W +: W], 60);
    chk("basic_cyc", snap_cyc_o, 15);
    chk("basic_id", snap_id_o, 0);
    snap_ready_i = 1;
    idle(1);
    snap_ready_i = 0;
    hpm[0] = 64'hFFFF_FFFF_FFFF_FFFB;
    hpm[5] = 7;
    step(1, TA, SV);
    idle(2);
    hpm[0] = 3;
    hpm[5] = 1000;
    step(1, TA, PV);
    chk("wrap_delta0", snap_delta_o[0 +: W], 8);
    chk("masked_delta5", snap_delta_o[5*W +: W], 0);
    snap_ready_i = 1;
    idle(1);
    snap_ready_i = 0;
    step(1, TA, PV);
    chk("idle_stop_valid", snap_valid_o, 0);
    step(1, 12'h321, SV);
    chk("other_addr_busy", busy_o, 0);
    step(1, TA, SV);
    idle(3);
    step(1, TA, SV);
    idle(5);
    step(1, TA, PV);
    chk("restart_cyc", snap_cyc_o, 6);
    chk("restart_id", snap_id_o, 2);
    snap_ready_i = 1;
    idle(1);
    reset_dut(1);
    snap_ready_i = 0;
    repeat (5) window(2);
    chk("bp_ovf", ovf_o, 1);
    chk("bp_drop", drop_cnt_o, 1);
    chk("bp_head_id", snap_id_o, 0);
    snap_ready_i = 1;
    idle(6);
    chk("bp_drained", exp_q.size(), 0);
    reset_dut(1);
    snap_ready_i = 0;
    repeat (4) window(1);
    step(1, TA, SV);
    idle(1);
    snap_ready_i = 1;
    step(1, TA, PV);
    chk("full_pushpop_drop", drop_cnt_o, 0);
    snap_ready_i = 0;
    window(1);
    chk("full_still4_drop", drop_cnt_o, 1);
    step(1, TA, SV);
    idle(2);
    reset_dut(1);
    for (int k = 0; k < 600; k++) begin
      int r;
      r = $urandom_range(0, 9);
      snap_ready_i = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 15) == 0) hpm[$urandom_range(0, N-1)] = {$urandom, $urandom};
      if (r < 2) step(1, TA, SV);
      else if (r < 4) step(1, TA, PV);
      else if (r == 4) step(1, 12'h321, SV);
      else if (r == 5) step(1, TA, $urandom);
      else idle(1);
    end
    snap_ready_i = 1;
    idle(8);
    chk("final_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
